// File: rtl/multiciclo_memory.sv
// -----------------------------------------------------------------------------
// multiciclo_memory
//
// Unified instruction/data memory responder for the multicycle RISC-V core.
// Each access is started by a one-cycle strobe in IDLE, spends WAIT_STATES
// extra cycles in ACCESS, performs the array operation on the edge that leaves
// ACCESS, and signals completion with a one-cycle ready pulse in RESPOND.
// Loads and stores are little-endian byte/half/word accesses selected by the
// RISC-V funct3 encoding.
//
// Parameters
//   ADDR_WIDTH   word-address width, array depth = 2**ADDR_WIDTH words
//   WAIT_STATES  extra ACCESS cycles before the array operation (0..15)
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   address        byte address, sampled with a strobe
//   write_data     store data, sampled with a strobe (low lanes for SB/SH)
//   read_request   one-cycle read strobe
//   write_request  one-cycle write strobe (wins over a simultaneous read)
//   size           funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   read_data      extended load result, held until the next completed read
//   ready          one-cycle completion pulse
//   busy           high whenever the responder is not idle
//   misaligned     qualifies ready: the access was rejected
// -----------------------------------------------------------------------------
module multiciclo_memory #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [2:0]  size,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic [ADDR_WIDTH+1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [2:0]              size_reg;
  logic                    write_op_reg;
  logic [31:0]             read_data_reg;
  logic                    mis_reg;

  logic                    accept;   // strobe taken in IDLE
  logic                    do_op;    // array operation on this edge

  // Only the word-index and lane bits of the address matter; the rest are
  // deliberately ignored so that accesses wrap modulo the array size.
  logic unused_high_addr;
  assign unused_high_addr = ^address[31:ADDR_WIDTH+2];

  // ---------------------------------------------------------------------------
  // Access decode (from the captured request)
  // ---------------------------------------------------------------------------
  // Byte and half are recognised from size[1:0] alone, which folds the
  // unsigned load variants and the 1xx store variants onto their 0xx
  // counterparts. Everything else (010, 011, 110, 111) is a word access.
  logic                  access_byte;
  logic                  access_half;
  logic                  access_word;
  logic                  load_unsigned;
  logic                  misaligned_access;
  logic [ADDR_WIDTH-1:0] word_index;
  logic [3:0]            lane_enable;
  logic [31:0]           store_data;
  logic [31:0]           mem_word;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_value;

  assign access_byte   = (size_reg[1:0] == 2'b00);
  assign access_half   = (size_reg[1:0] == 2'b01);
  assign access_word   = !access_byte && !access_half;
  assign load_unsigned = size_reg[2];

  assign misaligned_access = (access_half && addr_reg[0]) ||
                             (access_word && (addr_reg[1:0] != 2'b00));

  assign word_index = addr_reg[ADDR_WIDTH+1:2];

  always_comb begin
    lane_enable = 4'b1111;
    store_data  = wdata_reg;
    if (access_byte) begin
      lane_enable = 4'b0001 << addr_reg[1:0];
      store_data  = {4{wdata_reg[7:0]}};
    end else if (access_half) begin
      lane_enable = addr_reg[1] ? 4'b1100 : 4'b0011;
      store_data  = {2{wdata_reg[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so a store only rewrites its own
  // lanes; this is the read-modify-write of the addressed word without an
  // extra read cycle. Contents are intentionally not reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];

      always_ff @(posedge clock) begin
        if (do_op && write_op_reg && !misaligned_access && lane_enable[gi]) begin
          lane_mem[word_index] <= store_data[gi*8 +: 8];
        end
      end

      assign mem_word[gi*8 +: 8] = lane_mem[word_index];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = mem_word[7:0];
    case (addr_reg[1:0])
      2'd0:    load_byte = mem_word[7:0];
      2'd1:    load_byte = mem_word[15:8];
      2'd2:    load_byte = mem_word[23:16];
      default: load_byte = mem_word[31:24];
    endcase
    load_half = addr_reg[1] ? mem_word[31:16] : mem_word[15:0];

    load_value = mem_word;
    if (access_byte) begin
      load_value = load_unsigned ? {24'd0, load_byte}
                                 : {{24{load_byte[7]}}, load_byte};
    end else if (access_half) begin
      load_value = load_unsigned ? {16'd0, load_half}
                                 : {{16{load_half[15]}}, load_half};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state / strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    do_op      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (read_request || write_request) begin
          accept     = 1'b1;
          count_next = WAIT_INIT;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (count_reg == 4'd0) begin
          do_op      = 1'b1;
          state_next = RESPOND;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESPOND: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      size_reg      <= 3'd0;
      write_op_reg  <= 1'b0;
      read_data_reg <= 32'd0;
      mis_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        addr_reg     <= address[ADDR_WIDTH+1:0];
        wdata_reg    <= write_data;
        size_reg     <= size;
        // A simultaneous read strobe is simply dropped: write wins.
        write_op_reg <= write_request;
      end
      if (do_op) begin
        mis_reg <= misaligned_access;
        // Writes and rejected loads leave the last load result in place.
        if (!write_op_reg && !misaligned_access) begin
          read_data_reg <= load_value;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, so they clear with reset at once.
  // ---------------------------------------------------------------------------
  assign read_data  = read_data_reg;
  assign ready      = (state_reg == RESPOND);
  assign busy       = (state_reg != IDLE);
  // mis_reg is only refreshed on the operation edge, so gating with ready
  // keeps misaligned low outside the completion cycle.
  assign misaligned = ready && mis_reg;

endmodule

// File: tb/tb_multiciclo_memory.sv
// -----------------------------------------------------------------------------
// tb_multiciclo_memory
//
// Directed bench for multiciclo_memory. Instance "a" uses WAIT_STATES=1 and
// runs a table of accesses with hand-computed results; instance "b" uses
// WAIT_STATES=3 for the reset-during-access and reset-during-respond cases.
// -----------------------------------------------------------------------------
module tb_multiciclo_memory;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance a (WAIT_STATES = 1)
  logic        a_reset_n;
  logic [31:0] a_address, a_write_data, a_read_data;
  logic        a_read_request, a_write_request;
  logic [2:0]  a_size;
  logic        a_ready, a_busy, a_misaligned;

  // Instance b (WAIT_STATES = 3)
  logic        b_reset_n;
  logic [31:0] b_address, b_write_data, b_read_data;
  logic        b_read_request, b_write_request;
  logic [2:0]  b_size;
  logic        b_ready, b_busy, b_misaligned;

  multiciclo_memory #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
    .clock         (clock),
    .reset_n       (a_reset_n),
    .address       (a_address),
    .write_data    (a_write_data),
    .read_request  (a_read_request),
    .write_request (a_write_request),
    .size          (a_size),
    .read_data     (a_read_data),
    .ready         (a_ready),
    .busy          (a_busy),
    .misaligned    (a_misaligned)
  );

  multiciclo_memory #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_b (
    .clock         (clock),
    .reset_n       (b_reset_n),
    .address       (b_address),
    .write_data    (b_write_data),
    .read_request  (b_read_request),
    .write_request (b_write_request),
    .size          (b_size),
    .read_data     (b_read_data),
    .ready         (b_ready),
    .busy          (b_busy),
    .misaligned    (b_misaligned)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called just after a rising edge with the selected DUT idle. Issues one
  // strobe, waits (bounded) for ready, and returns once back in IDLE.
  task automatic access(input bit use_b, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] sz, input string tag,
                        output int lat, output logic [31:0] rdata, output logic mis);
    logic found;
    found = 1'b0;
    lat   = 0;
    rdata = 32'd0;
    mis   = 1'b0;
    #1;
    if (use_b) begin
      b_address = addr; b_write_data = wd; b_size = sz;
      b_write_request = wr; b_read_request = rd;
    end else begin
      a_address = addr; a_write_data = wd; a_size = sz;
      a_write_request = wr; a_read_request = rd;
    end
    @(posedge clock);
    #1;
    if (use_b) begin b_write_request = 1'b0; b_read_request = 1'b0; end
    else begin a_write_request = 1'b0; a_read_request = 1'b0; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0) check({tag, " busy after strobe"}, 32'(use_b ? b_busy : a_busy), 32'd1);
      if (use_b ? b_ready : a_ready) begin
        found = 1'b1;
        break;
      end
      @(posedge clock);
      lat++;
    end
    check({tag, " ready seen"}, 32'(found), 32'd1);
    if (found) begin
      rdata = use_b ? b_read_data : a_read_data;
      mis   = use_b ? b_misaligned : a_misaligned;
      @(posedge clock);
      #1;
      check({tag, " ready one cycle"}, 32'(use_b ? b_ready : a_ready), 32'd0);
      check({tag, " busy falls"}, 32'(use_b ? b_busy : a_busy), 32'd0);
    end else begin
      lat = -1;
    end
    $display("%s: wr=%b rd=%b addr=%h wd=%h size=%b -> lat=%0d read_data=%h misaligned=%b",
             tag, wr, rd, addr, wd, sz, lat, rdata, mis);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    int          pulses;
    logic        mis_seen;
    logic        found;

    // Directed table for instance a (WAIT_STATES=1, latency 2)
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 3'b010, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h12345680, 3'b000, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b010, 32'h80000000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hABCD1234, 3'b001, 32'h00000080, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b010, 32'h80001234, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,        3'b010, 32'h80001234, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0011, 32'hFFFFFFFF, 3'b001, 32'h80001234, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b010, 32'h80001234, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,        3'b001, 32'hFFFF8000, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,        3'b101, 32'h00008000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0011, 32'h0,        3'b000, 32'h00000012, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0011, 32'h000000FF, 3'b100, 32'h00000012, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b010, 32'h8000FF34, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b001, 32'hFFFFFF34, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        3'b000, 32'h00000034, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 32'h0000_1000, 32'h00000055, 3'b010, 32'h00000034, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,        3'b010, 32'h00000055, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 32'h0000_0020, 32'h11223344, 3'b010, 32'h00000055, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,        3'b010, 32'h11223344, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0,        3'b011, 32'h11223344, 1'b1};
    vecs[24] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFEF00D, 3'b111, 32'h11223344, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,        3'b110, 32'hCAFEF00D, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0000BEEF, 3'b101, 32'hCAFEF00D, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,        3'b010, 32'hBEEFF00D, 1'b0};
    vecs[28] = '{1'b0, 1'b1, 32'h0000_0023, 32'h0,        3'b000, 32'hFFFFFFBE, 1'b0};
    vecs[29] = '{1'b0, 1'b1, 32'hFFFF_F000, 32'h0,        3'b010, 32'h00000055, 1'b0};

    a_reset_n = 1'b0; b_reset_n = 1'b0;
    a_address = 32'd0; a_write_data = 32'd0; a_size = 3'd0;
    a_read_request = 1'b0; a_write_request = 1'b0;
    b_address = 32'd0; b_write_data = 32'd0; b_size = 3'd0;
    b_read_request = 1'b0; b_write_request = 1'b0;

    // Reset state
    #12;
    check("reset a read_data",  a_read_data,         32'd0);
    check("reset a ready",      32'(a_ready),        32'd0);
    check("reset a busy",       32'(a_busy),         32'd0);
    check("reset a misaligned", 32'(a_misaligned),   32'd0);
    check("reset b read_data",  b_read_data,         32'd0);
    check("reset b busy",       32'(b_busy),         32'd0);
    @(negedge clock);
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    @(posedge clock);

    // Table-driven accesses on instance a
    for (int i = 0; i < NVEC; i++) begin
      access(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].sz,
             $sformatf("vec%0d", i), lat, rdata, mis);
      check($sformatf("vec%0d latency", i),    32'(lat), 32'd2);
      check($sformatf("vec%0d read_data", i),  rdata,    vecs[i].exp_rdata);
      check($sformatf("vec%0d misaligned", i), 32'(mis), 32'(vecs[i].exp_mis));
    end

    // Strobes while busy are dropped: one ready, no array change
    access(1'b0, 1'b1, 1'b0, 32'h34, 32'h12121212, 3'b010, "preload34", lat, rdata, mis);
    #1;
    a_address = 32'h30; a_write_data = 32'h77; a_size = 3'b010; a_write_request = 1'b1;
    @(posedge clock);
    #1;
    a_address = 32'h34; a_write_data = 32'h99; a_read_request = 1'b1; a_write_request = 1'b1;
    pulses = 0;
    mis_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (a_ready) pulses++;
      if (a_misaligned) mis_seen = 1'b1;
      if (k == 3) begin
        a_read_request = 1'b0;
        a_write_request = 1'b0;
      end
    end
    $display("busy-drop: ready pulses=%0d busy=%b", pulses, a_busy);
    check("busy-drop ready pulses", 32'(pulses), 32'd1);
    check("busy-drop misaligned", 32'(mis_seen), 32'd0);
    check("busy-drop idle", 32'(a_busy), 32'd0);
    @(posedge clock);
    access(1'b0, 1'b0, 1'b1, 32'h34, 32'h0, 3'b010, "read34", lat, rdata, mis);
    check("busy-drop word34", rdata, 32'h12121212);
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 3'b010, "read30", lat, rdata, mis);
    check("busy-drop word30", rdata, 32'h00000077);

    // Instance b, WAIT_STATES=3: reset in ACCESS aborts the write
    access(1'b1, 1'b1, 1'b0, 32'h20, 32'h1111, 3'b010, "b_sw20", lat, rdata, mis);
    check("b latency", 32'(lat), 32'd4);
    access(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 3'b010, "b_lw20", lat, rdata, mis);
    check("b lw20 first", rdata, 32'h1111);
    #1;
    b_address = 32'h20; b_write_data = 32'hAAAA; b_size = 3'b010; b_write_request = 1'b1;
    @(posedge clock);
    #1;
    b_write_request = 1'b0;
    @(posedge clock);
    #2;
    check("b busy before reset", 32'(b_busy), 32'd1);
    b_reset_n = 1'b0;
    #1;
    $display("reset in ACCESS: read_data=%h ready=%b busy=%b misaligned=%b",
             b_read_data, b_ready, b_busy, b_misaligned);
    check("b reset read_data",  b_read_data,       32'd0);
    check("b reset ready",      32'(b_ready),      32'd0);
    check("b reset busy",       32'(b_busy),       32'd0);
    check("b reset misaligned", 32'(b_misaligned), 32'd0);
    @(negedge clock);
    b_reset_n = 1'b1;
    @(posedge clock);
    access(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 3'b010, "b_lw20_after", lat, rdata, mis);
    check("b aborted write", rdata, 32'h1111);

    // Reset in RESPOND: ready clears at once, committed write stays
    #1;
    b_address = 32'h24; b_write_data = 32'hBBBB; b_size = 3'b010; b_write_request = 1'b1;
    @(posedge clock);
    #1;
    b_write_request = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (b_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("b respond reached", 32'(found), 32'd1);
    b_reset_n = 1'b0;
    #1;
    $display("reset in RESPOND: ready=%b busy=%b", b_ready, b_busy);
    check("b respond reset ready", 32'(b_ready), 32'd0);
    @(negedge clock);
    b_reset_n = 1'b1;
    @(posedge clock);
    access(1'b1, 1'b0, 1'b1, 32'h24, 32'h0, 3'b010, "b_lw24", lat, rdata, mis);
    check("b committed write", rdata, 32'hBBBB);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
